// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared AXI4-Lite arbiter definitions: FSM states, response codes and requester count.
package axi4_lite_req_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi4_lite_req_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: the requester that did not own the bus last wins a tie.
module rr_arbiter2
  import axi4_lite_req_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic               any,
  output logic               winner
);

  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Arbitrates two AXI4-Lite style requesters onto a single master port, one transaction at a time,
// with direction-qualified completion and a WAIT-state timeout that answers SLVERR.
module axi4_lite_req_arbiter
  import axi4_lite_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic [1:0]                     req_VALID,
  input  logic [1:0]                     req_WE,
  input  logic [2*ADDR_WIDTH-1:0]        req_ADDR,
  input  logic [2*DATA_WIDTH-1:0]        req_WDATA,
  input  logic [2*(DATA_WIDTH/8)-1:0]    req_WSTRB,
  output logic [1:0]                     req_GNT,
  output logic [1:0]                     req_DONE,
  output logic [DATA_WIDTH-1:0]          req_RDATA,
  output logic [1:0]                     req_RESP,
  output logic                           write_req,
  output logic                           read_req,
  output logic [ADDR_WIDTH-1:0]          write_addr,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH/8-1:0]        write_strb,
  output logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic                           m_WDONE,
  input  logic [1:0]                     m_BRESP,
  input  logic                           m_RDONE,
  input  logic [1:0]                     m_RRESP,
  input  logic [DATA_WIDTH-1:0]          m_RDATA
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  arb_state_e state_q, state_d;

  logic                  last_q;
  logic                  owner_q;
  logic                  txn_we_q;
  logic [ADDR_WIDTH-1:0] txn_addr_q;
  logic [DATA_WIDTH-1:0] txn_wdata_q;
  logic [STRB_W-1:0]     txn_wstrb_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  early_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  arb_any;
  logic                  arb_winner;
  logic                  completion;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  timeout_hit;

  rr_arbiter2 u_rr (
    .req    (req_VALID),
    .last   (last_q),
    .any    (arb_any),
    .winner (arb_winner)
  );

  // Only the done strobe matching the latched direction can finish a transaction.
  assign completion  = txn_we_q ? m_WDONE : m_RDONE;
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (early_q || completion || timeout_hit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      txn_we_q    <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      txn_wstrb_q <= '0;
      cnt_q       <= '0;
      early_q     <= 1'b0;
      resp_q      <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            last_q      <= arb_winner;
            owner_q     <= arb_winner;
            early_q     <= 1'b0;
            txn_we_q    <= arb_winner ? req_WE[1] : req_WE[0];
            txn_addr_q  <= arb_winner ? req_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                      : req_ADDR[ADDR_WIDTH-1:0];
            txn_wdata_q <= arb_winner ? req_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : req_WDATA[DATA_WIDTH-1:0];
            txn_wstrb_q <= arb_winner ? req_WSTRB[2*STRB_W-1:STRB_W]
                                      : req_WSTRB[STRB_W-1:0];
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          // A master that answers in the issue cycle is remembered so WAIT exits at once.
          if (completion) begin
            early_q <= 1'b1;
            resp_q  <= txn_we_q ? m_BRESP : m_RRESP;
            rdata_q <= txn_we_q ? '0 : m_RDATA;
          end
        end
        ST_WAIT: begin
          if (!early_q) begin
            if (completion) begin
              resp_q  <= txn_we_q ? m_BRESP : m_RRESP;
              rdata_q <= txn_we_q ? '0 : m_RDATA;
            end else begin
              cnt_q <= cnt_inc;
              if (timeout_hit) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_GNT   = (state_q != ST_IDLE) ? owner_onehot(owner_q) : '0;
    req_DONE  = (state_q == ST_RESP) ? owner_onehot(owner_q) : '0;
    write_req = (state_q == ST_ISSUE) &&  txn_we_q;
    read_req  = (state_q == ST_ISSUE) && !txn_we_q;
  end

  assign write_addr = txn_addr_q;
  assign read_addr  = txn_addr_q;
  assign write_data = txn_wdata_q;
  assign write_strb = txn_wstrb_q;
  assign req_RDATA  = rdata_q;
  assign req_RESP   = resp_q;

endmodule

// File: doc/axi4_lite_req_arbiter.md
AXI4_LITE_REQ_ARBITER -- requirements
Module: axi4_lite_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of every requester and master-side address.
REQ-002 Parameter DATA_WIDTH, default 32, data width; the strobe width SHALL be DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 255, the number of cycles to wait for completion before the block aborts a transaction; TIMEOUT SHALL be at least 1.
REQ-004 The block SHALL have exactly one clock, iCLK, and SHALL use iRST as an asynchronous, active-low reset; the ports SHALL be named exactly iCLK and iRST.
REQ-005 Ports SHALL be as follows.
- iCLK, input, 1: clock.
- iRST, input, 1: async active-low reset.
- req_VALID, input, 2: per-requester request valid.
- req_WE, input, 2: per-requester write enable; 1 = write, 0 = read.
- req_ADDR, input, 2*ADDR_WIDTH: packed addresses; requester 0 in the low slice.
- req_WDATA, input, 2*DATA_WIDTH: packed write data.
- req_WSTRB, input, 2*(DATA_WIDTH/8): packed write strobes.
- req_GNT, output, 2: one-hot grant, held from acceptance until done.
- req_DONE, output, 2: one-cycle completion pulse to the owner.
- req_RDATA, output, DATA_WIDTH: read data, valid with req_DONE.
- req_RESP, output, 2: response, valid with req_DONE.
- write_req, output, 1: one-cycle write start to the master.
- read_req, output, 1: one-cycle read start to the master.
- write_addr, output, ADDR_WIDTH: master write address.
- write_data, output, DATA_WIDTH: master write data.
- write_strb, output, DATA_WIDTH/8: master write strobe.
- read_addr, output, ADDR_WIDTH: master read address.
- m_WDONE, input, 1: write complete, equal to BVALID&&BREADY.
- m_BRESP, input, 2: write response.
- m_RDONE, input, 1: read complete, equal to RVALID&&RREADY.
- m_RRESP, input, 2: read response.
- m_RDATA, input, DATA_WIDTH: read data.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with the following transitions.
- IDLE to ISSUE: when any req_VALID bit is 1.
- ISSUE to WAIT: unconditionally, after one cycle.
- WAIT to RESP: on completion or timeout.
- RESP to IDLE: unconditionally, after one cycle.
REQ-007 Arbitration in IDLE SHALL be round-robin with a 1-bit last-owner pointer.
- With both requesters valid, the non-last owner SHALL win.
- With one requester valid, that requester SHALL win.
- The pointer SHALL update to the winner on the IDLE to ISSUE transition.
REQ-008 On acceptance the block SHALL latch the winner's WE, ADDR, WDATA and WSTRB into a transaction register and SHALL assert the matching req_GNT bit from ISSUE through RESP inclusive.
REQ-009 In ISSUE the block SHALL pulse exactly one of write_req or read_req for one cycle, selected by the latched WE.
REQ-010 The addr, data and strb outputs SHALL drive the latched values from ISSUE through RESP and SHALL hold their last values otherwise.
REQ-011 Completion in WAIT SHALL be qualified by the latched direction.
- A write SHALL complete on m_WDONE and capture m_BRESP.
- A read SHALL complete on m_RDONE and capture m_RRESP and m_RDATA.
- The opposite-direction done signal SHALL be ignored.
REQ-012 Completion in the same cycle as ISSUE SHALL be captured: the block SHALL proceed to WAIT and then to RESP on the next cycle without a second master pulse.
REQ-013 The timeout counter SHALL behave as follows.
- It SHALL clear on entry to WAIT and increment each WAIT cycle without completion.
- When it reaches TIMEOUT, the block SHALL go to RESP with req_RESP=2'b10 (SLVERR) and req_RDATA=0.
- Completion in the same cycle as timeout SHALL take priority over the timeout.
REQ-014 In RESP the block SHALL assert the owner's req_DONE bit for exactly one cycle, with req_RDATA and req_RESP stable.
REQ-015 Latency from req_VALID sampled in IDLE to the write_req or read_req pulse SHALL be 1 cycle; latency from the completion cycle to req_DONE SHALL be 1 cycle.
REQ-016 A requester SHALL hold req_VALID until it sees its req_DONE; the block SHALL tolerate req_VALID being dropped mid-transaction and SHALL still complete the transaction.
REQ-017 At most one transaction SHALL be outstanding at any time.

Reset
REQ-018 Assertion of iRST SHALL immediately force the following values, including mid-transaction; any in-flight transaction SHALL be abandoned without a req_DONE pulse.
- FSM state: IDLE.
- Last-owner pointer: 1, so requester 0 has first priority.
- req_GNT, req_DONE, write_req, read_req: 0.
- All address, data, strb, response and counter registers: 0.

Structure
REQ-019 FSM state encodings, the SLVERR/OKAY response constants and the requester count (2) SHALL reside in a shared AXI4-Lite package.
REQ-020 The round-robin selector SHALL be implemented as one sub-module, rr_arbiter2.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with iRST released and the master model attached.
- Single write: req0 write to 0x10 with data 0xDEADBEEF; write_req pulses 1 cycle later with write_addr=0x10; m_WDONE with BRESP=00 yields req_DONE[0] 1 cycle later, req_RESP=00.
- Round-robin: both requesters read continuously; grants alternate 0,1,0,1 and req_RDATA returns the respective m_RDATA values.
- Timeout: TIMEOUT=4 with no m_RDONE; req_DONE occurs 4 WAIT cycles after entry with req_RESP=10 and req_RDATA=0.
- Direction filter: during a write, m_RDONE=1 is ignored and only m_WDONE completes the transaction.
- Reset mid-WAIT: iRST asserted mid-WAIT clears all outputs asynchronously; after release, req1 is served with no stale req_DONE.
- Same-cycle completion: m_WDONE asserted in the ISSUE cycle produces a single write_req pulse and req_DONE 2 cycles later.
